// File: rtl/trigger_capture_buf.sv
// trigger_capture_buf
//   Records a window of din samples around a trigger event into a circular
//   buffer (PRE samples before the trigger, the trigger sample, and
//   DEPTH-PRE-1 samples after it), then drains the window oldest-first over a
//   valid/ready interface.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   arm        start a capture (honoured only in IDLE)
//   abort      return to IDLE from any state; wins over arm
//   mode       trigger select: 00 rising edge of trig, 01 trig high,
//              10 din == pattern, 11 same as 00
//   trig       external trigger
//   pattern    match value for mode 10
//   din        sample input, one sample per cycle
//   dout       readout sample (holds the last sample after readout ends)
//   dout_valid dout holds a valid sample
//   rd_ready   consumer accepts dout
//   crfm       one-cycle pulse when a capture completes
//   armed      high in FILL, ARMED and POST
module trigger_capture_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PRE   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic          trig,
  input  logic [DW-1:0] pattern,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          rd_ready,
  output logic          crfm,
  output logic          armed
);

  localparam int unsigned     AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   ONE       = AW'(1);
  localparam logic [AW-1:0]   PRE_A     = AW'(PRE);
  localparam logic [AW-1:0]   FILL_LAST = AW'((PRE == 0) ? 0 : PRE - 1);
  localparam logic [AW-1:0]   POST_N    = AW'(DEPTH - PRE - 1);
  localparam logic [AW-1:0]   RD_LAST   = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_READ
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   tptr_q, tptr_d;
  logic [AW-1:0]   fill_q, fill_d;
  logic [AW-1:0]   post_q, post_d;
  logic [AW-1:0]   rdcnt_q, rdcnt_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            crfm_q, crfm_d;
  logic            trig_q;
  logic            hit;
  logic            we;

  logic [DW-1:0]   mem [DEPTH];

  // Trigger condition on current-cycle inputs; trig_q gives the edge history.
  always_comb begin
    hit = 1'b0;
    case (mode)
      2'b01:   hit = trig;
      2'b10:   hit = (din == pattern);
      default: hit = trig & ~trig_q;
    endcase
  end

  // dout is registered so it can reset to zero and hold the last sample once
  // readout ends; it is preloaded with mem[rptr] on the edge entering READ so
  // the first sample is visible in the same cycle as crfm.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    tptr_d  = tptr_q;
    fill_d  = fill_q;
    post_d  = post_q;
    rdcnt_d = rdcnt_q;
    dout_d  = dout_q;
    crfm_d  = 1'b0;
    we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          wptr_d  = '0;
          fill_d  = '0;
          state_d = (PRE == 0) ? S_ARMED : S_FILL;
        end
      end

      S_FILL: begin
        we     = 1'b1;
        wptr_d = wptr_q + ONE;
        fill_d = fill_q + ONE;
        if (fill_q == FILL_LAST) state_d = S_ARMED;
      end

      S_ARMED: begin
        we     = 1'b1;
        wptr_d = wptr_q + ONE;
        if (hit) begin
          tptr_d = wptr_q;
          post_d = POST_N;
          if (POST_N == '0) begin
            state_d = S_READ;
            crfm_d  = 1'b1;
            rptr_d  = wptr_q - PRE_A;
            rdcnt_d = '0;
            dout_d  = mem[wptr_q - PRE_A];
          end else begin
            state_d = S_POST;
          end
        end
      end

      S_POST: begin
        we     = 1'b1;
        wptr_d = wptr_q + ONE;
        post_d = post_q - ONE;
        if (post_q == ONE) begin
          state_d = S_READ;
          crfm_d  = 1'b1;
          rptr_d  = tptr_q - PRE_A;
          rdcnt_d = '0;
          dout_d  = mem[tptr_q - PRE_A];
        end
      end

      S_READ: begin
        if (rd_ready) begin
          rptr_d  = rptr_q + ONE;
          rdcnt_d = rdcnt_q + ONE;
          if (rdcnt_q == RD_LAST) state_d = S_IDLE;
          else                    dout_d  = mem[rptr_q + ONE];
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      crfm_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      tptr_q  <= '0;
      fill_q  <= '0;
      post_q  <= '0;
      rdcnt_q <= '0;
      dout_q  <= '0;
      crfm_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      tptr_q  <= tptr_d;
      fill_q  <= fill_d;
      post_q  <= post_d;
      rdcnt_q <= rdcnt_d;
      dout_q  <= dout_d;
      crfm_q  <= crfm_d;
      trig_q  <= trig;
    end
  end

  // Sample memory is not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == S_READ);
  assign crfm       = crfm_q;
  assign armed      = (state_q == S_FILL) || (state_q == S_ARMED) ||
                      (state_q == S_POST);

endmodule

// File: tb/tb_trigger_capture_buf.sv
module tb_trigger_capture_buf;

  localparam int DEPTH = 8;
  localparam int PRE   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm, abort, trig, rd_ready;
  logic [1:0] mode;
  logic [7:0] pattern, din;

  logic [7:0] dout0, dout1;
  logic       valid0, valid1, crfm0, crfm1, armed0, armed1;

  always #5 clk = ~clk;

  trigger_capture_buf #(.DW(8), .DEPTH(DEPTH), .PRE(PRE)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode(mode),
    .trig(trig), .pattern(pattern), .din(din), .dout(dout0),
    .dout_valid(valid0), .rd_ready(rd_ready), .crfm(crfm0), .armed(armed0)
  );

  trigger_capture_buf #(.DW(8), .DEPTH(DEPTH), .PRE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode(mode),
    .trig(trig), .pattern(pattern), .din(din), .dout(dout1),
    .dout_valid(valid1), .rd_ready(rd_ready), .crfm(crfm1), .armed(armed1)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  int         sel_g  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] v_g;
  logic [7:0] last_e;

  logic [7:0] s_dout;
  logic       s_valid, s_crfm, s_armed;
  assign s_dout  = (sel_g == 1) ? dout1  : dout0;
  assign s_valid = (sel_g == 1) ? valid1 : valid0;
  assign s_crfm  = (sel_g == 1) ? crfm1  : crfm0;
  assign s_armed = (sel_g == 1) ? armed1 : armed0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_capture(input logic [1:0] m, input logic [7:0] patt, input logic t);
    mode = m; pattern = patt; trig = t; rd_ready = 1'b1; arm = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  // Runs din from 0x10 until crfm appears; pushes the expected window when the
  // trigger sample is driven.
  task automatic capture(input int sel, input logic [1:0] m, input logic [7:0] tval, input bit held);
    int  pre, ti;
    bit  done;
    sel_g = sel;
    pre   = (sel == 1) ? 0 : PRE;
    start_capture(m, tval, held);
    exp_q.delete();
    v_g = 8'h10; ti = -1; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      din = v_g;
      if (!held) trig = (m == 2'b00) && (v_g == tval);
      if (v_g == tval && ti < 0) begin
        ti = c;
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(8'(int'(tval) - pre + k));
      end
      tick();
      v_g++;
      if (s_crfm) begin
        done = 1'b1;
        check("crfm_latency", 32'(c + 1 - ti), 32'(DEPTH - pre));
        check("valid_with_crfm", s_valid, 1);
      end
    end
    if (!done) check("crfm_timeout", 0, 1);
    trig = 1'b0;
  endtask

  task automatic readout(input bit bp, input int nx);
    int got;
    got = 0;
    for (int c = 0; c < 200 && got < nx; c++) begin
      rd_ready = bp ? (c % 3 == 0) : 1'b1;
      if (c == 1) check("crfm_one_cycle", s_crfm, 0);
      if (s_valid && rd_ready) begin
        if (exp_q.size() > 0) begin
          last_e = exp_q.pop_front();
          check("dout", s_dout, last_e);
        end else begin
          check("extra_transfer", 1, 0);
        end
        got++;
      end
      din = v_g;
      tick();
      v_g++;
    end
    if (got < nx) check("read_timeout", got, nx);
    rd_ready = 1'b1;
  endtask

  task automatic post_read();
    check("valid_drop", s_valid, 0);
    check("idle_armed", s_armed, 0);
    check("dout_hold", s_dout, last_e);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; rd_ready = 1'b1;
    mode = 2'b00; pattern = 8'h00; din = 8'h00;
    #12;
    check("rst_dout", dout0, 0);
    check("rst_valid", valid0, 0);
    check("rst_crfm", crfm0, 0);
    check("rst_armed", armed0, 0);
    rst_n = 1'b1;
    tick();

    // Edge trigger at 0x17.
    capture(0, 2'b00, 8'h17, 1'b0);
    readout(1'b0, DEPTH);
    post_read();

    // arm together with abort stays in IDLE.
    sel_g = 0;
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle", armed0, 0);

    // trig held high before arm, edge mode: never fires.
    start_capture(2'b00, 8'h00, 1'b1);
    cnt = 0;
    v_g = 8'h10;
    for (int c = 0; c < 30; c++) begin
      din = v_g; tick(); v_g++;
      if (crfm0) cnt++;
    end
    check("held_no_crfm", cnt, 0);
    check("held_armed", armed0, 1);

    // Same stimulus in level mode fires on the first ARMED cycle (0x13).
    capture(0, 2'b01, 8'h13, 1'b1);
    readout(1'b0, DEPTH);
    post_read();

    // Pattern trigger after many wraps.
    capture(0, 2'b10, 8'h2A, 1'b0);
    readout(1'b0, DEPTH);
    post_read();

    // Backpressure on readout.
    capture(0, 2'b00, 8'h17, 1'b0);
    readout(1'b1, DEPTH);
    post_read();

    // Abort during POST.
    sel_g = 0;
    start_capture(2'b00, 8'h00, 1'b0);
    v_g = 8'h10;
    while (v_g != 8'h1A) begin
      din = v_g; trig = (v_g == 8'h17); tick(); v_g++;
    end
    trig = 1'b0;
    check("post_armed", armed0, 1);
    abort = 1'b1; din = v_g; tick(); abort = 1'b0;
    check("abort_armed", armed0, 0);
    check("abort_valid", valid0, 0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      din = v_g; tick(); v_g++;
      if (crfm0 || valid0) cnt++;
    end
    check("abort_no_crfm", cnt, 0);

    // Reset in the middle of readout, then a fresh capture.
    capture(0, 2'b00, 8'h17, 1'b0);
    readout(1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid0, 0);
    check("midrst_dout", dout0, 0);
    check("midrst_armed", armed0, 0);
    #1 rst_n = 1'b1;
    capture(0, 2'b00, 8'h17, 1'b0);
    readout(1'b0, DEPTH);
    post_read();

    // PRE=0 instance: skips FILL.
    sel_g = 1;
    start_capture(2'b00, 8'h00, 1'b0);
    check("pre0_armed_now", armed1, 1);
    capture(1, 2'b00, 8'h12, 1'b0);
    readout(1'b0, DEPTH);
    post_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture_buf.md
# trigger_capture_buf

Parametrised successor to the single-word trigger capture block. It records a continuous window of `din` samples around a trigger event into a circular buffer, keeping `PRE` pre-trigger samples, the trigger sample and the post-trigger samples. After the window closes it drains the buffer oldest-first over a valid/ready interface. It sits between the sampled data bus and the debug/readout logic, and replaces the one-shot latch wherever history around an event is needed.

## Interface
Parameters:
- `DW`, 8, sample width in bits.
- `DEPTH`, 16, buffer depth in samples; power of two, ≥ 2.
- `PRE`, 4, pre-trigger samples kept; 0 ≤ PRE ≤ DEPTH-1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  start a capture; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state; wins over `arm`.
- `mode`  in  2  trigger select:
  - 00: rising edge of `trig`.
  - 01: `trig` high.
  - 10: `din == pattern`.
  - 11: treated as 00.
- `trig`  in  1  external trigger.
- `pattern`  in  DW  match value for mode 10.
- `din`  in  DW  sample input, one sample per cycle.
- `dout`  out  DW  readout sample.
- `dout_valid`  out  1  `dout` holds a valid sample.
- `rd_ready`  in  1  consumer accepts `dout`.
- `crfm`  out  1  one-cycle pulse when a capture completes.
- `armed`  out  1  high in FILL, ARMED and POST.

## Operation
States: IDLE, FILL, ARMED, POST, READ.
- **Reset:** state IDLE, `wptr`/`rptr`/counters 0, `trig_q` 0, `dout` 0, `dout_valid` 0, `crfm` 0, `armed` 0. Memory contents are not reset.
- **IDLE:**
  - `arm` high and `abort` low → FILL, `wptr`=0, fill count 0.
  - If PRE==0 → ARMED directly.
  - No writes occur in IDLE.
- **Writes:** on every edge in FILL, ARMED and POST, `mem[wptr] ← din`, then `wptr ← wptr+1 mod DEPTH`.
- **FILL:**
  - After PRE writes → ARMED.
  - Triggers are ignored in FILL.
- **ARMED:**
  - The trigger condition is evaluated on the current-cycle inputs.
  - In mode 00 the condition is `trig & ~trig_q`. `trig_q` is registered every cycle in all states, so a `trig` already high before ARMED does not fire.
  - On a hit, the sample written on that edge is the trigger sample. `tptr` ← its address, post count ← DEPTH-PRE-1.
  - Post count 0 → READ; otherwise → POST.
  - ARMED may last indefinitely. `wptr` wraps and keeps overwriting, so the latest PRE samples are always preserved.
- **POST:**
  - The post count decrements per write.
  - On the edge that writes the last post sample → READ, `crfm` high for that next cycle, `rptr` ← (tptr − PRE) mod DEPTH.
- **READ:**
  - `dout = mem[rptr]` (asynchronous memory read), `dout_valid` high.
  - On `dout_valid & rd_ready`: `rptr++` mod DEPTH, read count++.
  - After the DEPTH-th transfer → IDLE, and `dout_valid` drops on the next cycle.
  - `dout` holds the last sample after READ ends.
  - `arm` is ignored in READ.
- **abort:** in any state → IDLE on the next edge, and `dout_valid`, `crfm` and `armed` clear. An in-flight capture is discarded.
- **Reset mid-operation:** all outputs drop to their reset values immediately (asynchronous).

## Timing
- The arm→first write latency is 1 edge: the `arm` edge changes state only, and the next edge writes.
- Minimum capture length is PRE+1+(DEPTH-PRE-1) = DEPTH writes.
- The trigger-sample edge to `crfm` latency is DEPTH-PRE edges.
- `crfm` and `dout_valid` rise in the same cycle, and the first sample is available that cycle.
- With `rd_ready` held high, readout is one sample per cycle, DEPTH cycles total.
- `armed` reflects the state register, so it has no combinational path from inputs.
- Simultaneous `arm` and `abort` in IDLE → remains IDLE.

## Test plan
All scenarios use DW=8, DEPTH=8, PRE=3, with `din` counting 0x10, 0x11, … one value per cycle from the cycle after `arm`.
- **Edge trigger:** pulse `trig` in mode 00 when `din`=0x17, `rd_ready`=1 → `crfm` pulses 5 edges later; readout is 0x14, 0x15, 0x16, 0x17, 0x18, 0x19, 0x1A, 0x1B; then IDLE.
- **Held trigger, edge mode:** `trig` high before `arm`, never toggled → no capture, `armed` stays 1. In mode 01 the same stimulus triggers at 0x13, the first ARMED cycle, and readout is 0x10–0x17.
- **Pattern trigger with wrap:** mode 10, `pattern`=0x2A → trigger at 0x2A with `wptr` wrapped many times; readout is 0x27–0x2E.
- **Backpressure:** toggle `rd_ready` 1,0,0,1,… during READ → each sample is presented until accepted; no loss or duplication; exactly 8 transfers.
- **Abort/reset:**
  - `abort` during POST → IDLE next edge, `crfm` never pulses, `dout_valid` 0.
  - `rst_n` low mid-READ → `dout_valid` 0 immediately; a fresh `arm` then works normally.
- **PRE=0 variant:** trigger at 0x12 → no FILL state; readout is 0x12–0x19.
